// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encodings and hazard helper for the pipeline control unit
package pipe_ctrl_pkg;

  localparam int PCTRL_CNT_W = 3;

  typedef enum logic [1:0] {
    PCTRL_ST_RUN      = 2'd0,
    PCTRL_ST_LU_STALL = 2'd1,
    PCTRL_ST_FLUSH    = 2'd2
  } pctrl_state_e;

  // A load in EX feeding either source of the instruction in ID; x0 never creates a dependency.
  function automatic logic is_load_use(input logic       ex_load,
                                       input logic [4:0] ex_rd,
                                       input logic [4:0] id_rs1,
                                       input logic [4:0] id_rs2);
    return ex_load && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/pctrl_cnt.sv
// rtl/pctrl_cnt.sv - loadable down-counter shared by the stall and flush sequences
module pctrl_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = PCTRL_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         hold,
  output logic         is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I pipeline hold/flush/redirect control; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int WAIT_CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_mem_re_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_hold_o,
  output logic        pc_jump_o,
  output logic [31:0] pc_jump_addr_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        ex_mem_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mem_wb_bubble_o,
  output logic        err_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [1:0]  state_o
`else
  output logic [1:0]  state_o
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;

  pctrl_state_e state, next_state;
  logic freeze, hazard;
  logic cnt_load, cnt_dec, cnt_is_one;
  logic [PCTRL_CNT_W-1:0] cnt_load_val;
  logic pc_hold, pc_jump, if_id_hold, id_ex_hold, ex_mem_hold;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic err;

  assign freeze = mem_req_i & ~mem_ack_i;
  assign hazard = is_load_use(ex_mem_re_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PCTRL_ST_RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_dec       = 1'b0;
    pc_hold       = 1'b0;
    pc_jump       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      id_ex_hold    = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_jump_i) begin
      // A redirect wins in every state, including aborting a stall or restarting a flush.
      pc_jump     = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        cnt_load     = 1'b1;
        cnt_load_val = PCTRL_CNT_W'(FLUSH_CYCLES);
        next_state   = PCTRL_ST_FLUSH;
      end else begin
        next_state = PCTRL_ST_RUN;
      end
    end else begin
      case (state)
        PCTRL_ST_RUN: begin
          if (hazard) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              cnt_load     = 1'b1;
              cnt_load_val = PCTRL_CNT_W'(LU_STALL_CYCLES - 1);
              next_state   = PCTRL_ST_LU_STALL;
            end
          end
        end
        PCTRL_ST_LU_STALL: begin
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          cnt_dec     = 1'b1;
          if (cnt_is_one) next_state = PCTRL_ST_RUN;
        end
        PCTRL_ST_FLUSH: begin
          if_id_flush = 1'b1;
          cnt_dec     = 1'b1;
          if (cnt_is_one) next_state = PCTRL_ST_RUN;
        end
        default: next_state = PCTRL_ST_RUN;
      endcase
    end
  end

  pctrl_cnt #(.W(PCTRL_CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .hold     (freeze),
    .is_one   (cnt_is_one)
  );

  // Counts consecutive frozen cycles; saturates so a hung memory keeps err set without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (freeze) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_MAX - 1'b1) err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign pc_hold_o       = rst_n & pc_hold;
  assign pc_jump_o       = rst_n & pc_jump;
  assign pc_jump_addr_o  = (rst_n & pc_jump) ? ex_jump_addr_i : 32'd0;
  assign if_id_hold_o    = rst_n & if_id_hold;
  assign id_ex_hold_o    = rst_n & id_ex_hold;
  assign ex_mem_hold_o   = rst_n & ex_mem_hold;
  assign if_id_flush_o   = rst_n & if_id_flush;
  assign id_ex_flush_o   = rst_n & id_ex_flush;
  assign mem_wb_bubble_o = rst_n & mem_wb_bubble;
  assign err_o           = rst_n & err;
  assign state_o         = rst_n ? state : PCTRL_ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (pc_hold && (perf_stall_cnt_o != 32'hFFFF_FFFF)) perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
      if (if_id_flush && (perf_flush_cnt_o != 32'hFFFF_FFFF)) perf_flush_cnt_o <= perf_flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a behavioural reference model
module tb_pipe_ctrl;

  localparam int LU   = 2;
  localparam int FC   = 1;
  localparam int WW   = 8;
  localparam int WMAX = (1 << WW) - 1;

  // {pc_hold, pc_jump, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [7:0] HZD = 8'b1010_0010;
  localparam logic [7:0] JMP = 8'b0100_0110;
  localparam logic [7:0] FLS = 8'b0000_0100;
  localparam logic [7:0] FRZ = 8'b1011_1001;

  logic        clk, rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        mem_re, jump, req, ack;
  logic [31:0] jaddr;
  logic        pc_hold_o, pc_jump_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o;
  logic        if_id_flush_o, id_ex_flush_o, mem_wb_bubble_o, err_o;
  logic [31:0] pc_jump_addr_o;
  logic [1:0]  state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int m_stall, m_flush, m_wait, m_pstall, m_pflush;
  logic m_err;

  wire [42:0] obs = {pc_hold_o, pc_jump_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o,
                     if_id_flush_o, id_ex_flush_o, mem_wb_bubble_o, err_o, state_o, pc_jump_addr_o};
  wire [9:0]  cs  = {obs[42:35], state_o};

  pipe_ctrl #(.LU_STALL_CYCLES(LU), .FLUSH_CYCLES(FC), .WAIT_CNT_W(WW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_addr_i   (rs1),
    .id_rs2_addr_i   (rs2),
    .ex_rd_addr_i    (rd),
    .ex_mem_re_i     (mem_re),
    .ex_jump_i       (jump),
    .ex_jump_addr_i  (jaddr),
    .mem_req_i       (req),
    .mem_ack_i       (ack),
    .pc_hold_o       (pc_hold_o),
    .pc_jump_o       (pc_jump_o),
    .pc_jump_addr_o  (pc_jump_addr_o),
    .if_id_hold_o    (if_id_hold_o),
    .id_ex_hold_o    (id_ex_hold_o),
    .ex_mem_hold_o   (ex_mem_hold_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .mem_wb_bubble_o (mem_wb_bubble_o),
    .err_o           (err_o),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt_o(perf_stall),
    .perf_flush_cnt_o(perf_flush),
`endif
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; mem_re = 1'b0;
    jump = 1'b0; jaddr = 32'd0; req = 1'b0; ack = 1'b0;
  endtask

  function automatic logic m_haz();
    return mem_re && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Expected outputs: pending bubbles/flush slots decide the mode, freeze and jump override.
  function automatic logic [42:0] model_out();
    logic [7:0]  c;
    logic [1:0]  s;
    logic [31:0] a;
    c = 8'd0;
    a = 32'd0;
    s = (m_flush > 0) ? 2'd2 : (m_stall > 0) ? 2'd1 : 2'd0;
    if (req && !ack)                c = FRZ;
    else if (jump) begin            c = JMP; a = jaddr; end
    else if (m_flush > 0)           c = FLS;
    else if (m_stall > 0 || m_haz()) c = HZD;
    if (!rst_n) return 43'd0;
    return {c, m_err, s, a};
  endfunction

  task automatic model_step();
    logic [42:0] e;
    e = model_out();
    if (e[42]) m_pstall++;
    if (e[37]) m_pflush++;
    if (req && !ack) begin
      if (m_wait < WMAX) m_wait++;
      if (m_wait == WMAX) m_err = 1'b1;
    end else begin
      m_wait = 0;
      if (jump) begin
        m_flush = FC;
        m_stall = 0;
      end else if (m_flush > 0) m_flush--;
      else if (m_stall > 0)     m_stall--;
      else if (m_haz())         m_stall = LU - 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    jump = 1'b1; jaddr = 32'hDEAD_BEEF; mem_re = 1'b1; rd = 5'd5; rs1 = 5'd5;
    #1;
    n_chk++;
    if (obs !== 43'd0) begin n_fail++; $display("FAIL reset_jump: got %h expected 0", obs); end
    req = 1'b1;
    #1;
    n_chk++;
    if (obs !== 43'd0) begin n_fail++; $display("FAIL reset_freeze: got %h expected 0", obs); end
    @(negedge clk); idle(); rst_n = 1'b1;
    #1;
    n_chk++;
    if (obs !== 43'd0) begin n_fail++; $display("FAIL reset_release: got %h expected 0", obs); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    idle(); mem_re = 1'b1; rd = 5'd5; rs1 = 5'd5;
    #1;
    n_chk++;
    if (cs !== {HZD, 2'd0}) begin n_fail++; $display("FAIL lu_first: got %h expected %h", cs, {HZD, 2'd0}); end
    @(negedge clk); idle();
    #1;
    n_chk++;
    if (cs !== {HZD, 2'd1}) begin n_fail++; $display("FAIL lu_second: got %h expected %h", cs, {HZD, 2'd1}); end
    @(negedge clk);
    #1;
    n_chk++;
    if (cs !== 10'd0) begin n_fail++; $display("FAIL lu_done: got %h expected 0", cs); end
    @(negedge clk); mem_re = 1'b1; rd = 5'd0;
    #1;
    n_chk++;
    if (cs !== 10'd0) begin n_fail++; $display("FAIL lu_rd0: got %h expected 0", cs); end
    @(negedge clk); mem_re = 1'b0; rd = 5'd5; rs1 = 5'd5;
    #1;
    n_chk++;
    if (cs !== 10'd0) begin n_fail++; $display("FAIL lu_not_load: got %h expected 0", cs); end
    @(negedge clk); mem_re = 1'b1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7;
    #1;
    n_chk++;
    if (cs !== {HZD, 2'd0}) begin n_fail++; $display("FAIL lu_rs2: got %h expected %h", cs, {HZD, 2'd0}); end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_jump();
    idle(); jump = 1'b1; jaddr = 32'h0000_0100;
    #1;
    n_chk++;
    if ({cs, pc_jump_addr_o} !== {JMP, 2'd0, 32'h100}) begin
      n_fail++; $display("FAIL jump_take: got %h/%h expected %h/100", cs, pc_jump_addr_o, {JMP, 2'd0});
    end
    @(negedge clk); idle();
    #1;
    n_chk++;
    if ({cs, pc_jump_addr_o} !== {FLS, 2'd2, 32'd0}) begin
      n_fail++; $display("FAIL jump_flush: got %h/%h expected %h/0", cs, pc_jump_addr_o, {FLS, 2'd2});
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (cs !== 10'd0) begin n_fail++; $display("FAIL jump_done: got %h expected 0", cs); end
    @(negedge clk);
  endtask

  task automatic test_jump_over_hazard();
    idle(); mem_re = 1'b1; rd = 5'd5; rs1 = 5'd5; jump = 1'b1; jaddr = 32'h0000_0200;
    #1;
    n_chk++;
    if (cs !== {JMP, 2'd0}) begin n_fail++; $display("FAIL jh_take: got %h expected %h", cs, {JMP, 2'd0}); end
    @(negedge clk); idle();
    #1;
    n_chk++;
    if (cs !== {FLS, 2'd2}) begin n_fail++; $display("FAIL jh_state: got %h expected %h", cs, {FLS, 2'd2}); end
    @(negedge clk);
  endtask

  task automatic test_freeze_flush();
    idle(); jump = 1'b1; jaddr = 32'h0000_0300;
    @(negedge clk); idle(); req = 1'b1; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (cs !== {FRZ, 2'd2}) begin n_fail++; $display("FAIL frz_cycle%0d: got %h expected %h", i, cs, {FRZ, 2'd2}); end
      @(negedge clk);
    end
    ack = 1'b1;
    #1;
    n_chk++;
    if (cs !== {FLS, 2'd2}) begin n_fail++; $display("FAIL frz_resume: got %h expected %h", cs, {FLS, 2'd2}); end
    @(negedge clk); idle();
    #1;
    n_chk++;
    if (cs !== 10'd0) begin n_fail++; $display("FAIL frz_done: got %h expected 0", cs); end
    @(negedge clk); req = 1'b1; jump = 1'b1; jaddr = 32'h0000_0400;
    #1;
    n_chk++;
    if ({cs, pc_jump_addr_o} !== {FRZ, 2'd0, 32'd0}) begin
      n_fail++; $display("FAIL frz_jump_held: got %h/%h expected %h/0", cs, pc_jump_addr_o, {FRZ, 2'd0});
    end
    @(negedge clk); req = 1'b0;
    #1;
    n_chk++;
    if ({cs, pc_jump_addr_o} !== {JMP, 2'd0, 32'h400}) begin
      n_fail++; $display("FAIL frz_jump_taken: got %h/%h expected %h/400", cs, pc_jump_addr_o, {JMP, 2'd0});
    end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    idle(); req = 1'b1; ack = 1'b0;
    repeat (254) @(negedge clk);
    #1;
    n_chk++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", err_o); end
    @(negedge clk);
    #1;
    n_chk++;
    if ({err_o, cs} !== {1'b1, FRZ, 2'd0}) begin
      n_fail++; $display("FAIL timeout_set: got %h expected %h", {err_o, cs}, {1'b1, FRZ, 2'd0});
    end
    @(negedge clk); ack = 1'b1;
    @(negedge clk); idle();
    #1;
    n_chk++;
    if ({err_o, cs} !== {1'b1, 10'd0}) begin
      n_fail++; $display("FAIL timeout_sticky: got %h expected %h", {err_o, cs}, {1'b1, 10'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    idle(); mem_re = 1'b1; rd = 5'd9; rs1 = 5'd9;
    @(negedge clk); idle();
    #1;
    n_chk++;
    if (cs !== {HZD, 2'd1}) begin n_fail++; $display("FAIL rms_in_stall: got %h expected %h", cs, {HZD, 2'd1}); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 43'd0) begin n_fail++; $display("FAIL rms_async: got %h expected 0", obs); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_chk++;
    if (obs !== 43'd0) begin n_fail++; $display("FAIL rms_run: got %h expected 0", obs); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [42:0] e;
    idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_stall = 0; m_flush = 0; m_wait = 0; m_err = 1'b0; m_pstall = 0; m_pflush = 0;
    for (int i = 0; i < 600; i++) begin
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 3));
      mem_re = 1'($urandom_range(0, 1));
      jump   = ($urandom_range(0, 5) == 0);
      jaddr  = $urandom;
      req    = ($urandom_range(0, 3) == 0);
      ack    = 1'($urandom_range(0, 1));
      #1;
      e = model_out();
      n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL rand_cycle%0d: got %h expected %h", i, obs, e); end
      model_step();
      @(negedge clk);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_chk++;
    if ({perf_stall, perf_flush} !== {32'(m_pstall), 32'(m_pflush)}) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", perf_stall, perf_flush, m_pstall, m_pflush);
    end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_jump_over_hazard();
    test_freeze_flush();
    test_timeout();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
